// File: rtl/sdp_y_int_core_lanes.sv
// Multi-lane integer Y-path core: per-lane multiply/PReLU stage (S1) then ALU stage (S2),
// each registered with valid/ready flow control, plus lane masking and a saturation-event counter.
module sdp_y_int_core_lanes #(
    parameter int LANES = 4,
    parameter int DW    = 32
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  cfg_mul_bypass,
    input  logic                  cfg_mul_prelu,
    input  logic                  cfg_mul_src,
    input  logic [DW-1:0]         cfg_mul_op,
    input  logic [5:0]            cfg_mul_truncate,
    input  logic                  cfg_alu_bypass,
    input  logic                  cfg_alu_src,
    input  logic [1:0]            cfg_alu_algo,
    input  logic [DW-1:0]         cfg_alu_op,
    input  logic [LANES-1:0]      cfg_lane_mask,
    input  logic                  sat_clr,
    input  logic                  chn_in_pvld,
    output logic                  chn_in_prdy,
    input  logic [LANES*DW-1:0]   chn_data_in,
    input  logic                  chn_mul_op_pvld,
    output logic                  chn_mul_op_prdy,
    input  logic [LANES*DW-1:0]   chn_mul_op,
    input  logic                  chn_alu_op_pvld,
    output logic                  chn_alu_op_prdy,
    input  logic [LANES*DW-1:0]   chn_alu_op,
    output logic                  chn_out_pvld,
    input  logic                  chn_out_prdy,
    output logic [LANES*DW-1:0]   chn_data_out,
    output logic [31:0]           sat_cnt
);

    localparam int PW = 2*DW + 1;

    // Returns {saturated, result}. One guard bit above the 2*DW product keeps the rounding add exact.
    function automatic logic [DW:0] mul_lane(input logic [DW-1:0] x, input logic [DW-1:0] m,
                                             input logic [5:0] t);
        logic signed [PW-1:0] xe, me, p, rnd, smax, smin;
        xe   = {{(DW+1){x[DW-1]}}, x};
        me   = {{(DW+1){m[DW-1]}}, m};
        p    = xe * me;
        rnd  = '0;
        smax = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
        smin = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
        if (t != 6'd0) begin
            rnd = PW'(1) << (t - 6'd1);
            p   = (p + rnd) >>> t;
        end
        if (p > smax)
            mul_lane = {1'b1, 1'b0, {(DW-1){1'b1}}};
        else if (p < smin)
            mul_lane = {1'b1, 1'b1, {(DW-1){1'b0}}};
        else
            mul_lane = {1'b0, p[DW-1:0]};
    endfunction

    function automatic logic [DW:0] alu_lane(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [1:0] algo);
        logic [DW:0] s;
        s        = '0;
        alu_lane = '0;
        case (algo)
            2'd0: alu_lane = {1'b0, ($signed(a) > $signed(b)) ? a : b};
            2'd1: alu_lane = {1'b0, ($signed(a) < $signed(b)) ? a : b};
            2'd2: begin
                s = {a[DW-1], a} + {b[DW-1], b};
                if (s[DW] != s[DW-1])
                    alu_lane = {1'b1, s[DW], {(DW-1){~s[DW]}}};
                else
                    alu_lane = {1'b0, s[DW-1:0]};
            end
            default: alu_lane = {1'b0, {(DW-1){1'b0}}, (a == b)};
        endcase
    endfunction

    function automatic logic [5:0] popcnt(input logic [LANES-1:0] v);
        popcnt = '0;
        for (int i = 0; i < LANES; i++)
            popcnt = popcnt + 6'(v[i]);
    endfunction

    logic                  s1_vld, s2_vld;
    logic [LANES*DW-1:0]   s1_data, s2_data;
    logic [LANES*DW-1:0]   s1_next, s2_next;
    logic [LANES-1:0]      mul_sat, alu_sat;
    logic                  need_mul, need_alu;
    logic                  s1_rdy, s2_rdy, s1_cap, s2_take;
    logic [5:0]            sat_inc;
    logic [32:0]           sat_sum;

    assign need_mul = !cfg_mul_bypass && cfg_mul_src;
    assign need_alu = !cfg_alu_bypass && cfg_alu_src;

    // Ready chain runs back from the output so a full pipe can drain and refill in one cycle.
    assign s2_rdy  = !s2_vld || chn_out_prdy;
    assign s2_take = s1_vld && (!need_alu || chn_alu_op_pvld) && s2_rdy;
    assign s1_rdy  = !s1_vld || s2_take;
    assign s1_cap  = chn_in_pvld && (!need_mul || chn_mul_op_pvld) && s1_rdy;

    assign chn_in_prdy     = s1_rdy && (!need_mul || chn_mul_op_pvld);
    assign chn_mul_op_prdy = need_mul && s1_rdy && chn_in_pvld;
    assign chn_alu_op_prdy = need_alu && s1_vld && s2_rdy;

    assign chn_out_pvld = s2_vld;
    assign chn_data_out = s2_data;

    always_comb begin
        logic [DW-1:0] x, m, a, b;
        logic [DW:0]   r;
        s1_next = '0;
        s2_next = '0;
        mul_sat = '0;
        alu_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            x = chn_data_in[DW*i +: DW];
            m = cfg_mul_src ? chn_mul_op[DW*i +: DW] : cfg_mul_op;
            if (cfg_mul_bypass || (cfg_mul_prelu && !x[DW-1]))
                r = {1'b0, x};
            else
                r = mul_lane(x, m, cfg_mul_truncate);
            if (cfg_lane_mask[i]) begin
                s1_next[DW*i +: DW] = r[DW-1:0];
                mul_sat[i]          = r[DW];
            end

            a = s1_data[DW*i +: DW];
            b = cfg_alu_src ? chn_alu_op[DW*i +: DW] : cfg_alu_op;
            if (cfg_alu_bypass)
                r = {1'b0, a};
            else
                r = alu_lane(a, b, cfg_alu_algo);
            if (cfg_lane_mask[i]) begin
                s2_next[DW*i +: DW] = r[DW-1:0];
                alu_sat[i]          = r[DW];
            end
        end
    end

    assign sat_inc = (s1_cap ? popcnt(mul_sat) : 6'd0) + (s2_take ? popcnt(alu_sat) : 6'd0);
    assign sat_sum = {1'b0, sat_clr ? 32'd0 : sat_cnt} + 33'(sat_inc);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s2_vld  <= 1'b0;
            s2_data <= '0;
            sat_cnt <= '0;
        end else begin
            if (s1_cap) begin
                s1_vld  <= 1'b1;
                s1_data <= s1_next;
            end else if (s2_take) begin
                s1_vld  <= 1'b0;
            end

            if (s2_take) begin
                s2_vld  <= 1'b1;
                s2_data <= s2_next;
            end else if (chn_out_prdy) begin
                s2_vld  <= 1'b0;
            end

            sat_cnt <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
        end
    end

endmodule

// File: doc/sdp_y_int_core_lanes.md
# sdp_y_int_core_lanes

Parametrised multi-lane integer Y-path core for the SDP element-wise datapath: per lane, an optional multiply/PReLU stage with rounding truncation and saturation, followed by an ALU stage (MAX/MIN/SUM/EQL). Both stages are registered with valid/ready flow control and run at full throughput. The block adds a lane-mask and a saturation-event counter over the previous fixed-lane core. It sits between the Y-path LUT/convert front end and the SDP output mux.

## Interface
- LANES, 4, number of parallel lanes (1..16)
- DW, 32, lane data width in bits (16..32), two's complement
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- cfg_mul_bypass / cfg_mul_prelu / cfg_mul_src  in  1 each  mul stage bypass / PReLU mode / operand source (0 = cfg_mul_op, 1 = chn_mul_op)
- cfg_mul_op  in  DW  register multiplier operand
- cfg_mul_truncate  in  6  arithmetic right-shift amount after multiply
- cfg_alu_bypass / cfg_alu_src  in  1 each  ALU bypass / operand source (0 = cfg_alu_op, 1 = chn_alu_op)
- cfg_alu_algo  in  2  0 MAX, 1 MIN, 2 SUM, 3 EQL
- cfg_alu_op  in  DW  register ALU operand
- cfg_lane_mask  in  LANES  1 = lane active; inactive lanes output 0
- sat_clr  in  1  single-cycle clear of sat_cnt
- chn_in_pvld / chn_in_prdy  in / out  1  input beat handshake
- chn_data_in  in  LANES*DW  lane i at [DW*i+DW-1 : DW*i]
- chn_mul_op_pvld / chn_mul_op_prdy  in / out  1;  chn_mul_op  in  LANES*DW
- chn_alu_op_pvld / chn_alu_op_prdy  in / out  1;  chn_alu_op  in  LANES*DW
- chn_out_pvld / chn_out_prdy  out / in  1;  chn_data_out  out  LANES*DW
- sat_cnt  out  32  saturating count of lane saturation events

## Operation
- Mul operand needed (NM) = !cfg_mul_bypass && cfg_mul_src; ALU operand needed (NA) = !cfg_alu_bypass && cfg_alu_src.
- Mul stage per lane (x = input, m = operand): bypass -> x. PReLU and x >= 0 -> x unchanged. Otherwise p = x*m (signed, 2*DW bits); if t = cfg_mul_truncate > 0, p = (p + 2^(t-1)) >>> t; then saturate to signed DW. A clamp is one saturation event.
- ALU stage per lane (a = mul result, b = operand): bypass -> a. MAX/MIN signed. SUM = a+b, saturated to DW (one event on clamp). EQL -> 1 if a==b, else 0.
- Masked lanes: output 0, never count saturation. Mask and cfg are sampled per stage at the cycle of stage capture; they must be static while a layer is in flight.
- sat_cnt += popcount of saturation events of beats captured this cycle in S1 and in S2; saturates at 0xFFFF_FFFF. sat_clr with a simultaneous increment -> sat_cnt = that cycle's increment.

## Timing
- Two register stages, S1 (mul) and S2 (ALU, drives the outputs); latency 2 cycles from input accept to chn_out_pvld; 1 beat/cycle sustained.
- s1_rdy = !s1_vld || s2_take; s2_rdy = !s2_vld || chn_out_prdy.
- S1 capture = chn_in_pvld && (!NM || chn_mul_op_pvld) && s1_rdy. chn_in_prdy = s1_rdy && (!NM || chn_mul_op_pvld). chn_mul_op_prdy = NM && s1_rdy && chn_in_pvld, else 0.
- s2_take = s1_vld && (!NA || chn_alu_op_pvld) && s2_rdy. chn_alu_op_prdy = NA && s1_vld && s2_rdy, else 0. An unneeded operand channel is never popped.
- prdy outputs are combinational from pvld inputs and stage state; no prdy output depends on another prdy output.
- chn_out_pvld = s2_vld; data is held stable while pvld && !prdy.
- Reset: s1_vld = s2_vld = 0, chn_out_pvld = 0, chn_data_out = 0, sat_cnt = 0. chn_in_prdy is 1 after reset when NM = 0. Reset mid-stream discards all in-flight beats.
- Full: both stages valid and chn_out_prdy = 0 -> chn_in_prdy = 0 and chn_alu_op_prdy = 0. A simultaneous drain and fill captures the new beat in the same cycle, so there are no bubbles.

## Test plan
- LANES=4, DW=32, all bypass, stream 0,1,2,3... with prdy=1 -> identical data out, pvld 2 cycles after the first accept, 1 beat/cycle, sat_cnt = 0.
- Mul from cfg, op = 3, truncate = 1, x = 5 -> (15+1)>>>1 = 8. x = -5 -> -7. x = 0x4000_0000, truncate = 0 -> 0x7FFF_FFFF, sat_cnt += 1 per lane.
- PReLU, op = 2, truncate = 0: x = 7 -> 7; x = -7 -> -14. ALU SUM, cfg op = 0x7FFF_FFFF, a = 1 -> 0x7FFF_FFFF with a saturation event; EQL with a = b -> 1.
- NM = NA = 1, random pvld on the in/mul-op/alu-op channels and random chn_out_prdy (50%) -> scoreboard match, no beat lost or duplicated, output held stable under stall, operands popped exactly once per beat.
- cfg_lane_mask = 4'b0101 with saturating inputs -> lanes 1 and 3 output 0, sat_cnt counts only lanes 0 and 2. sat_clr coincident with 2 events -> sat_cnt = 2.
- Assert reset with both stages full -> chn_out_pvld = 0 immediately. After release, the first new beat appears 2 cycles after accept with no stale data.
